// File: rtl/alu_res_station.sv
// ALU reservation station: holds dispatched ops until both operands resolve via the CDB, then issues one per cycle.
// Define RS_OLDEST_FIRST_EN for age-ordered (oldest ready first) issue; default issues lowest-index ready entry.
module alu_res_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [2:0]        ld_funct3,
  input  logic              ld_funct7b,
  input  logic [TAG_W-1:0]  ld_dest,
  input  logic              ld_rj,
  input  logic              ld_rk,
  input  logic [DATA_W-1:0] ld_vj,
  input  logic [DATA_W-1:0] ld_vk,
  input  logic [TAG_W-1:0]  ld_qj,
  input  logic [TAG_W-1:0]  ld_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              alu_ready,
  output logic              issue_valid,
  output logic [2:0]        issue_funct3,
  output logic              issue_funct7b,
  output logic [TAG_W-1:0]  issue_dest,
  output logic [DATA_W-1:0] issue_a,
  output logic [DATA_W-1:0] issue_b,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  rj_q;
  logic [DEPTH-1:0]  rk_q;
  logic [DEPTH-1:0]  f7_q;
  logic [2:0]        funct3_q [DEPTH];
  logic [TAG_W-1:0]  dest_q   [DEPTH];
  logic [TAG_W-1:0]  qj_q     [DEPTH];
  logic [TAG_W-1:0]  qk_q     [DEPTH];
  logic [DATA_W-1:0] vj_q     [DEPTH];
  logic [DATA_W-1:0] vk_q     [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic              lock_q, lock_d;
  logic [IW-1:0]     lock_idx_q;

  logic [DEPTH-1:0]  rdy;
  logic [IW-1:0]     free_idx;
  logic              free_found;
  logic [IW-1:0]     sel_idx;
  logic              sel_found;
  logic              do_load;
  logic              do_issue;
  logic              bypass_j;
  logic              bypass_k;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic              older_exists;
`endif

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = valid_q[i] && rj_q[i] && rk_q[i];
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    older_exists = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older_exists = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy[j] && age_q[j][i]) older_exists = 1'b1;
      end
      if (rdy[i] && !older_exists && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = i[IW-1:0];
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = i[IW-1:0];
      end
    end
`endif
    // A stalled issue keeps presenting the same entry even if another becomes preferable
    if (lock_q && rdy[lock_idx_q]) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx_q;
    end
  end

  assign issue_valid   = !flush && sel_found;
  assign issue_funct3  = issue_valid ? funct3_q[sel_idx] : '0;
  assign issue_funct7b = issue_valid ? f7_q[sel_idx]     : 1'b0;
  assign issue_dest    = issue_valid ? dest_q[sel_idx]   : '0;
  assign issue_a       = issue_valid ? vj_q[sel_idx]     : '0;
  assign issue_b       = issue_valid ? vk_q[sel_idx]     : '0;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;

  assign do_load  = load && !full && !flush;
  assign do_issue = issue_valid && alu_ready;
  assign bypass_j = cdb_valid && (ld_qj == cdb_tag);
  assign bypass_k = cdb_valid && (ld_qk == cdb_tag);

  always_comb begin
    count_d = count_q;
    lock_d  = issue_valid && !alu_ready;
    if (flush) begin
      count_d = '0;
      lock_d  = 1'b0;
    end else if (do_load && !do_issue) begin
      count_d = count_q + CW'(1);
    end else if (!do_load && do_issue) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      rj_q       <= '0;
      rk_q       <= '0;
      f7_q       <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        funct3_q[i] <= '0;
        dest_q[i]   <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
      end
    end else begin
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= sel_idx;
      if (flush) begin
        valid_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && !rj_q[i] && cdb_valid && (qj_q[i] == cdb_tag)) begin
            rj_q[i] <= 1'b1;
            vj_q[i] <= cdb_value;
          end
          if (valid_q[i] && !rk_q[i] && cdb_valid && (qk_q[i] == cdb_tag)) begin
            rk_q[i] <= 1'b1;
            vk_q[i] <= cdb_value;
          end
        end
        if (do_issue) valid_q[sel_idx] <= 1'b0;
        // The slot is chosen from pre-edge state, so a slot freed this cycle is never reused here
        if (do_load) begin
          valid_q[free_idx]  <= 1'b1;
          funct3_q[free_idx] <= ld_funct3;
          f7_q[free_idx]     <= ld_funct7b;
          dest_q[free_idx]   <= ld_dest;
          qj_q[free_idx]     <= ld_qj;
          qk_q[free_idx]     <= ld_qk;
          rj_q[free_idx]     <= ld_rj || bypass_j;
          rk_q[free_idx]     <= ld_rk || bypass_k;
          vj_q[free_idx]     <= ld_rj ? ld_vj : cdb_value;
          vk_q[free_idx]     <= ld_rk ? ld_vk : cdb_value;
        end
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (do_load) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_q[free_idx][j] <= 1'b0;
        age_q[j][free_idx] <= valid_q[j];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_res_station.sv
// Scoreboard bench for alu_res_station: stimulus pushes expected issues, a monitor pops on each handshake.
module tb_alu_res_station;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 3;
   localparam int DATA_W = 32;
   localparam int CW     = $clog2(DEPTH) + 1;

   typedef struct {
      logic [2:0]        f3;
      logic              f7;
      logic [TAG_W-1:0]  dest;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } expT;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              load;
   logic [2:0]        ldFunct3;
   logic              ldFunct7b;
   logic [TAG_W-1:0]  ldDest;
   logic              ldRj;
   logic              ldRk;
   logic [DATA_W-1:0] ldVj;
   logic [DATA_W-1:0] ldVk;
   logic [TAG_W-1:0]  ldQj;
   logic [TAG_W-1:0]  ldQk;
   logic              cdbValid;
   logic [TAG_W-1:0]  cdbTag;
   logic [DATA_W-1:0] cdbValue;
   logic              aluReady;
   logic              issueValid;
   logic [2:0]        issueFunct3;
   logic              issueFunct7b;
   logic [TAG_W-1:0]  issueDest;
   logic [DATA_W-1:0] issueA;
   logic [DATA_W-1:0] issueB;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;

   expT expQ[$];
   int  testsRun    = 0;
   int  testsFailed = 0;

   alu_res_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .load(load),
      .ld_funct3(ldFunct3), .ld_funct7b(ldFunct7b), .ld_dest(ldDest),
      .ld_rj(ldRj), .ld_rk(ldRk), .ld_vj(ldVj), .ld_vk(ldVk),
      .ld_qj(ldQj), .ld_qk(ldQk),
      .cdb_valid(cdbValid), .cdb_tag(cdbTag), .cdb_value(cdbValue),
      .alu_ready(aluReady),
      .issue_valid(issueValid), .issue_funct3(issueFunct3), .issue_funct7b(issueFunct7b),
      .issue_dest(issueDest), .issue_a(issueA), .issue_b(issueB),
      .full(full), .empty(empty), .count(count)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [2:0] f3, input logic f7, input logic [TAG_W-1:0] dest,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      expT e;
      e.f3 = f3; e.f7 = f7; e.dest = dest; e.a = a; e.b = b;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [2:0] f3, input logic f7, input logic [TAG_W-1:0] dest,
                                input logic rj, input logic [DATA_W-1:0] vj, input logic [TAG_W-1:0] qj,
                                input logic rk, input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] qk);
      load = 1'b1; ldFunct3 = f3; ldFunct7b = f7; ldDest = dest;
      ldRj = rj; ldVj = vj; ldQj = qj;
      ldRk = rk; ldVk = vk; ldQk = qk;
      tick();
      load = 1'b0;
   endtask

   // Monitor: every accepted issue is compared against the oldest expected entry
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (rst && issueValid && aluReady) begin
            testsRun++;
            if (expQ.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL unexpectedIssue: got dest=%0d a=%0h b=%0h, required no issue",
                        issueDest, issueA, issueB);
            end else begin
               e = expQ.pop_front();
               if (issueFunct3 !== e.f3 || issueFunct7b !== e.f7 || issueDest !== e.dest ||
                   issueA !== e.a || issueB !== e.b) begin
                  testsFailed++;
                  $display("[TB] FAIL issue: got f3=%0d f7=%0b dest=%0d a=%0h b=%0h, required f3=%0d f7=%0b dest=%0d a=%0h b=%0h",
                           issueFunct3, issueFunct7b, issueDest, issueA, issueB,
                           e.f3, e.f7, e.dest, e.a, e.b);
               end
            end
         end
      end
   end

   // Directed sequence covering reset, wakeup, bypass, stall, ordering and flush
   initial begin
      rst = 1'b0; flush = 1'b0; load = 1'b0; aluReady = 1'b0;
      ldFunct3 = '0; ldFunct7b = 1'b0; ldDest = '0; ldRj = 1'b0; ldRk = 1'b0;
      ldVj = '0; ldVk = '0; ldQj = '0; ldQk = '0;
      cdbValid = 1'b0; cdbTag = '0; cdbValue = '0;
      #3;
      checkOutput("resetCount", 32'(count), 0);
      checkOutput("resetEmpty", 32'(empty), 1);
      checkOutput("resetFull", 32'(full), 0);
      checkOutput("resetIssueValid", 32'(issueValid), 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Reset in the middle of operation
      for (int k = 1; k <= 3; k++) applyStimulus(3'(k), 1'b0, 3'(k), 1'b1, 32'h1, 3'd0, 1'b1, 32'h1, 3'd0);
      checkOutput("midCount3", 32'(count), 3);
      checkOutput("midIssueDest", 32'(issueDest), 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("midRstCount", 32'(count), 0);
      checkOutput("midRstEmpty", 32'(empty), 1);
      checkOutput("midRstIssueValid", 32'(issueValid), 0);
      checkOutput("midRstIssueA", issueA, 0);
      #1 rst = 1'b1;
      tick();

      // Ready dispatch issues the following cycle
      aluReady = 1'b1;
      pushExp(3'd0, 1'b0, 3'd2, 32'd5, 32'd7);
      applyStimulus(3'd0, 1'b0, 3'd2, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0);
      checkOutput("readyIssueValid", 32'(issueValid), 1);
      checkOutput("readyIssueA", issueA, 5);
      tick();
      checkOutput("readyEmpty", 32'(empty), 1);

      // CDB wakeup of operand j
      pushExp(3'd0, 1'b0, 3'd3, 32'h10, 32'd1);
      applyStimulus(3'd0, 1'b0, 3'd3, 1'b0, 32'd0, 3'd4, 1'b1, 32'd1, 3'd0);
      checkOutput("wakeWaitValid0", 32'(issueValid), 0);
      tick();
      checkOutput("wakeWaitValid1", 32'(issueValid), 0);
      cdbValid = 1'b1; cdbTag = 3'd4; cdbValue = 32'h10;
      tick();
      cdbValid = 1'b0;
      checkOutput("wakeIssueValid", 32'(issueValid), 1);
      checkOutput("wakeIssueA", issueA, 32'h10);
      tick();
      checkOutput("wakeEmpty", 32'(empty), 1);

      // Same-cycle CDB bypass on dispatch
      pushExp(3'd5, 1'b1, 3'd4, 32'd3, 32'hAB);
      cdbValid = 1'b1; cdbTag = 3'd6; cdbValue = 32'hAB;
      applyStimulus(3'd5, 1'b1, 3'd4, 1'b1, 32'd3, 3'd0, 1'b0, 32'd0, 3'd6);
      cdbValid = 1'b0;
      checkOutput("bypassIssueValid", 32'(issueValid), 1);
      checkOutput("bypassIssueB", issueB, 32'hAB);
      tick();
      checkOutput("bypassEmpty", 32'(empty), 1);

      // Fill to capacity under stall, then drain
      aluReady = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         pushExp(3'(k), 1'b0, 3'(k), 32'h100 + 32'(k), 32'(k));
         applyStimulus(3'(k), 1'b0, 3'(k), 1'b1, 32'h100 + 32'(k), 3'd0, 1'b1, 32'(k), 3'd0);
      end
      checkOutput("fullFlag", 32'(full), 1);
      checkOutput("fullCount", 32'(count), DEPTH);
      applyStimulus(3'd7, 1'b0, 3'd7, 1'b1, 32'hDEAD, 3'd0, 1'b1, 32'd0, 3'd0);
      checkOutput("fullIgnoredCount", 32'(count), DEPTH);
      aluReady = 1'b1;
      #1;
      checkOutput("fullBeforeIssue", 32'(full), 1);
      tick();
      checkOutput("fullAfterIssue", 32'(full), 0);
      checkOutput("countAfterIssue", 32'(count), DEPTH - 1);
      for (int k = 0; k < DEPTH - 1; k++) tick();
      checkOutput("drainEmpty", 32'(empty), 1);

      // Simultaneous dispatch and issue keeps count constant
      aluReady = 1'b0;
      pushExp(3'd1, 1'b0, 3'd5, 32'hA, 32'hA);
      applyStimulus(3'd1, 1'b0, 3'd5, 1'b1, 32'hA, 3'd0, 1'b1, 32'hA, 3'd0);
      aluReady = 1'b1;
      pushExp(3'd2, 1'b0, 3'd6, 32'hB, 32'hB);
      applyStimulus(3'd2, 1'b0, 3'd6, 1'b1, 32'hB, 3'd0, 1'b1, 32'hB, 3'd0);
      checkOutput("simulCount", 32'(count), 1);
      tick();
      checkOutput("simulEmpty", 32'(empty), 1);

      // Ordering: free entry 0, reload it, then wake everything at once
      aluReady = 1'b0;
      applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 32'd0, 3'd1, 1'b1, 32'h20, 3'd0);
      for (int k = 1; k < DEPTH; k++)
         applyStimulus(3'd0, 1'b0, 3'(k), 1'b0, 32'd0, 3'd6, 1'b1, 32'h20 + 32'(k), 3'd0);
      pushExp(3'd0, 1'b0, 3'd0, 32'h11, 32'h20);
      cdbValid = 1'b1; cdbTag = 3'd1; cdbValue = 32'h11;
      aluReady = 1'b1;
      tick();
      cdbValid = 1'b0;
      tick();
      aluReady = 1'b0;
      checkOutput("orderCount3", 32'(count), 3);
      applyStimulus(3'd0, 1'b0, 3'd4, 1'b0, 32'd0, 3'd6, 1'b1, 32'h24, 3'd0);
      checkOutput("orderCount4", 32'(count), 4);
`ifdef RS_OLDEST_FIRST_EN
      for (int k = 1; k <= 4; k++) pushExp(3'd0, 1'b0, 3'(k), 32'h66, 32'h20 + 32'(k));
`else
      pushExp(3'd0, 1'b0, 3'd4, 32'h66, 32'h24);
      for (int k = 1; k <= 3; k++) pushExp(3'd0, 1'b0, 3'(k), 32'h66, 32'h20 + 32'(k));
`endif
      cdbValid = 1'b1; cdbTag = 3'd6; cdbValue = 32'h66;
      aluReady = 1'b1;
      tick();
      cdbValid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checkOutput("orderEmpty", 32'(empty), 1);

      // Flush overrides pending entries and a concurrent load
      aluReady = 1'b0;
      applyStimulus(3'd3, 1'b0, 3'd1, 1'b1, 32'h5, 3'd0, 1'b1, 32'h5, 3'd0);
      applyStimulus(3'd3, 1'b0, 3'd2, 1'b1, 32'h6, 3'd0, 1'b1, 32'h6, 3'd0);
      checkOutput("preFlushValid", 32'(issueValid), 1);
      flush = 1'b1;
      #1;
      checkOutput("flushCycleValid", 32'(issueValid), 0);
      applyStimulus(3'd3, 1'b0, 3'd3, 1'b1, 32'h7, 3'd0, 1'b1, 32'h7, 3'd0);
      flush = 1'b0;
      checkOutput("flushEmpty", 32'(empty), 1);
      checkOutput("flushCount", 32'(count), 0);
      checkOutput("flushIssueValid", 32'(issueValid), 0);
      aluReady = 1'b1;
      tick();
      tick();
      aluReady = 1'b0;

      checkOutput("scoreboardDrained", 32'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
